// File: rtl/pipe_cond_controller.sv
// Pipelined ARM control unit: decodes in D, resolves condition codes in E,
// and carries write/PC-source control through MEM_STAGES memory stages to W.
module pipe_cond_controller #(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned ALUCTRL_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:12]         InstrD,
  input  logic [3:0]           ALUFlagsE,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 UndefD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 BranchTakenE,
  output logic                 MemtoRegE,
  output logic [3:0]           FlagsE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 MemtoRegW,
  output logic                 RegWriteW,
  output logic                 PCSrcW,
  output logic                 PCWrPendingF
);

  typedef struct packed {
    logic                 regWrite;
    logic                 memWrite;
    logic                 memtoReg;
    logic                 branch;
    logic                 pcSrc;
    logic [1:0]           flagWrite;
    logic [3:0]           cond;
    logic                 aluSrc;
    logic [ALUCTRL_W-1:0] aluControl;
  } ctrl_t;

  ctrl_t                 ctrlD, ctrlE;
  logic                  undef;
  logic [2:0]            aluCode;
  logic                  condExE;
  logic [3:0]            flags;
  logic                  memWriteM1;
  logic [MEM_STAGES-1:0] regWriteMq, memtoRegMq, pcSrcMq;
  logic                  unusedInstr;

  assign unusedInstr = ^InstrD[19:16];

  // Decode
  always_comb begin
    ctrlD      = '0;
    undef      = 1'b0;
    aluCode    = 3'b000;
    RegSrcD    = 2'b00;
    ImmSrcD    = 2'b00;
    ctrlD.cond = InstrD[31:28];
    unique case (InstrD[27:26])
      2'b00: begin
        ctrlD.aluSrc   = InstrD[25];
        ctrlD.regWrite = 1'b1;
        unique case (InstrD[24:21])
          4'b0100: aluCode = 3'b000;
          4'b0010: aluCode = 3'b001;
          4'b0000: aluCode = 3'b010;
          4'b1100: aluCode = 3'b011;
          4'b0001: aluCode = 3'b100;
          4'b1101: aluCode = 3'b101;
          4'b1010: begin aluCode = 3'b001; ctrlD.regWrite = 1'b0; end
          4'b1000: begin aluCode = 3'b010; ctrlD.regWrite = 1'b0; end
          default: undef = 1'b1;
        endcase
        ctrlD.flagWrite[1] = InstrD[20];
        ctrlD.flagWrite[0] = InstrD[20] & ((InstrD[24:21] == 4'b0100) |
                                           (InstrD[24:21] == 4'b0010) |
                                           (InstrD[24:21] == 4'b1010));
      end
      2'b01: begin
        ctrlD.aluSrc = 1'b1;
        ImmSrcD      = 2'b01;
        if (InstrD[20]) begin
          ctrlD.memtoReg = 1'b1;
          ctrlD.regWrite = 1'b1;
        end else begin
          ctrlD.memWrite = 1'b1;
          RegSrcD        = 2'b10;
        end
      end
      2'b10: begin
        ctrlD.aluSrc = 1'b1;
        ctrlD.branch = 1'b1;
        ImmSrcD      = 2'b10;
        RegSrcD      = 2'b01;
      end
      default: undef = 1'b1;
    endcase
    if (undef) begin
      ctrlD.regWrite  = 1'b0;
      ctrlD.memWrite  = 1'b0;
      ctrlD.memtoReg  = 1'b0;
      ctrlD.branch    = 1'b0;
      ctrlD.flagWrite = 2'b00;
    end
    ctrlD.aluControl = ALUCTRL_W'(aluCode);
    ctrlD.pcSrc      = ((InstrD[15:12] == 4'hF) & ctrlD.regWrite) | ctrlD.branch;
  end

  assign UndefD = undef;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ctrlE <= '0;
    else if (FlushE)  ctrlE <= '0;
    else if (!StallE) ctrlE <= ctrlD;
  end

  always_comb begin
    case (ctrlE.cond)
      4'b0000: condExE = flags[2];
      4'b0001: condExE = ~flags[2];
      4'b0010: condExE = flags[1];
      4'b0011: condExE = ~flags[1];
      4'b0100: condExE = flags[3];
      4'b0101: condExE = ~flags[3];
      4'b0110: condExE = flags[0];
      4'b0111: condExE = ~flags[0];
      4'b1000: condExE = flags[1] & ~flags[2];
      4'b1001: condExE = ~(flags[1] & ~flags[2]);
      4'b1010: condExE = ~(flags[3] ^ flags[0]);
      4'b1011: condExE = flags[3] ^ flags[0];
      4'b1100: condExE = ~flags[2] & ~(flags[3] ^ flags[0]);
      4'b1101: condExE = flags[2] | (flags[3] ^ flags[0]);
      4'b1110: condExE = 1'b1;
      default: condExE = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (condExE && !StallE) begin
      if (ctrlE.flagWrite[1]) flags[3:2] <= ALUFlagsE[3:2];
      if (ctrlE.flagWrite[0]) flags[1:0] <= ALUFlagsE[1:0];
    end
  end

  // A stalled instruction stays in E, so M1 takes a bubble until it leaves;
  // the concat-and-truncate shift keeps MEM_STAGES = 1 legal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memWriteM1 <= 1'b0;
      regWriteMq <= '0;
      memtoRegMq <= '0;
      pcSrcMq    <= '0;
    end else begin
      memWriteM1 <= ctrlE.memWrite & condExE & ~StallE;
      regWriteMq <= MEM_STAGES'({regWriteMq, ctrlE.regWrite & condExE & ~StallE});
      memtoRegMq <= MEM_STAGES'({memtoRegMq, ctrlE.memtoReg & ~StallE});
      pcSrcMq    <= MEM_STAGES'({pcSrcMq, ctrlE.pcSrc & condExE & ~StallE});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      RegWriteW <= regWriteMq[MEM_STAGES-1];
      MemtoRegW <= memtoRegMq[MEM_STAGES-1];
      PCSrcW    <= pcSrcMq[MEM_STAGES-1];
    end
  end

  assign ALUSrcE      = ctrlE.aluSrc;
  assign ALUControlE  = ctrlE.aluControl;
  assign BranchTakenE = ctrlE.branch & condExE;
  assign MemtoRegE    = ctrlE.memtoReg;
  assign FlagsE       = flags;
  assign MemWriteM    = memWriteM1;
  assign RegWriteM    = regWriteMq[0];
  assign PCWrPendingF = ctrlD.pcSrc | ctrlE.pcSrc | (|pcSrcMq);

endmodule

// File: tb/tb_pipe_cond_controller.sv
// Bench for pipe_cond_controller: directed scenarios with literal expectations,
// then random instruction streams checked against an instruction-level model.
module tb_pipe_cond_controller;
  localparam int MS = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:12]  InstrD = '0;
  logic [3:0]    ALUFlagsE = '0;
  logic          StallE = 1'b0;
  logic          FlushE = 1'b0;
  logic [1:0]    RegSrcD, ImmSrcD;
  logic          UndefD, ALUSrcE, BranchTakenE, MemtoRegE;
  logic [AW-1:0] ALUControlE;
  logic [3:0]    FlagsE;
  logic          MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

  int tests = 0;
  int fails = 0;

  pipe_cond_controller #(.MEM_STAGES(MS), .ALUCTRL_W(AW)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE),
    .StallE(StallE), .FlushE(FlushE), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
    .UndefD(UndefD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .FlagsE(FlagsE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .MemtoRegW(MemtoRegW),
    .RegWriteW(RegWriteW), .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic       rw, mw, m2r, br, pcs;
    logic [1:0] fw;
    logic [3:0] cond;
    logic       src;
    logic [2:0] alu;
    logic       undef;
    logic [1:0] rs, is;
  } refE_t;

  typedef struct packed {
    logic rw, mw, m2r, pcs;
  } refM_t;

  function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic refE_t refDecode(input logic [31:12] w);
    refE_t r;
    bit known;
    r = '0;
    r.cond = w[31:28];
    case (w[27:26])
      2'b00: begin
        known = 1'b1;
        r.src = w[25];
        case (w[24:21])
          4'b0100, 4'b1010: r.alu = 3'd0;
          default: r.alu = 3'd0;
        endcase
        case (w[24:21])
          4'b0100: r.alu = 3'd0;
          4'b0010: r.alu = 3'd1;
          4'b0000: r.alu = 3'd2;
          4'b1100: r.alu = 3'd3;
          4'b0001: r.alu = 3'd4;
          4'b1101: r.alu = 3'd5;
          4'b1010: r.alu = 3'd1;
          4'b1000: r.alu = 3'd2;
          default: known = 1'b0;
        endcase
        if (known) begin
          r.rw = !(w[24:21] inside {4'b1010, 4'b1000});
          r.fw = {w[20], w[20] && (w[24:21] inside {4'b0100, 4'b0010, 4'b1010})};
        end else begin
          r.undef = 1'b1;
        end
      end
      2'b01: begin
        r.src = 1'b1;
        r.is  = 2'b01;
        if (w[20]) begin r.m2r = 1'b1; r.rw = 1'b1; end
        else begin r.mw = 1'b1; r.rs = 2'b10; end
      end
      2'b10: begin
        r.src = 1'b1; r.br = 1'b1; r.is = 2'b10; r.rs = 2'b01;
      end
      default: r.undef = 1'b1;
    endcase
    r.pcs = (r.rw && (w[15:12] == 4'hF)) || r.br;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; InstrD = 20'hE0810; #1;
    tests++;
    if ({FlagsE, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, MemWriteM, RegWriteM,
         MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF} !== '0) begin
      fails++; $display("FAIL reset_initial: outputs not all zero");
    end
    tick();
    reset = 1'b1; InstrD = 20'hE0910; ALUFlagsE = 4'hF;
    tick();
    InstrD = 20'hEA000;
    tick();
    InstrD = 20'hE0810;
    tick();
    tests++;
    if ({FlagsE, PCWrPendingF} !== {4'hF, 1'b1}) begin
      fails++; $display("FAIL reset_preload: got %h expected %h", {FlagsE, PCWrPendingF}, {4'hF, 1'b1});
    end
    #2; reset = 1'b0; #1;
    tests++;
    if ({FlagsE, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, MemWriteM, RegWriteM,
         MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF} !== '0) begin
      fails++;
      $display("FAIL reset_async: flags %b pend %b got nonzero, expected all zero", FlagsE, PCWrPendingF);
    end
    InstrD = 20'hEC000; #1;
    tests++;
    if (UndefD !== 1'b1) begin fails++; $display("FAIL reset_decode_comb: got %b expected 1", UndefD); end
    InstrD = 20'hE1510; ALUFlagsE = 4'h0; #1;
    reset = 1'b1;
    tick();
    tests++;
    if (ALUControlE !== 4'h1) begin
      fails++; $display("FAIL reset_release_sample: got %h expected 1", ALUControlE);
    end
  endtask

  task automatic test_flag_cond();
    for (int pass = 0; pass < 2; pass++) begin
      InstrD = 20'hE0910; ALUFlagsE = 4'h0;
      tick();
      ALUFlagsE = (pass == 0) ? 4'b0100 : 4'b0000;
      InstrD = 20'h00810;
      tick();
      tests++;
      if (FlagsE !== ((pass == 0) ? 4'b0100 : 4'b0000)) begin
        fails++; $display("FAIL flag_write pass %0d: got %b", pass, FlagsE);
      end
      ALUFlagsE = 4'h0; InstrD = 20'hE0810;
      tick();
      tests++;
      if (RegWriteM !== ((pass == 0) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL cond_eq pass %0d: got %b expected %b", pass, RegWriteM, pass == 0);
      end
    end
  endtask

  task automatic test_compare();
    InstrD = 20'hE1510;
    tick();
    tests++;
    if (ALUControlE !== 4'h1) begin fails++; $display("FAIL cmp_aluctl: got %h expected 1", ALUControlE); end
    ALUFlagsE = 4'b1010; InstrD = 20'hE0810;
    tick();
    tests++;
    if ({FlagsE, RegWriteM} !== {4'b1010, 1'b0}) begin
      fails++; $display("FAIL cmp_flags: got %b expected %b", {FlagsE, RegWriteM}, {4'b1010, 1'b0});
    end
  endtask

  task automatic test_branch();
    logic [6:0] bt, pw, ps;
    bt = '0; pw = '0; ps = '0;
    ALUFlagsE = 4'h0; InstrD = 20'hEA000; #1;
    bt[0] = BranchTakenE; pw[0] = PCWrPendingF; ps[0] = PCSrcW;
    for (int c = 1; c < 7; c++) begin
      tick();
      InstrD = 20'hE0810; #1;
      bt[c] = BranchTakenE; pw[c] = PCWrPendingF; ps[c] = PCSrcW;
    end
    tests++;
    if (bt !== 7'b0000010) begin fails++; $display("FAIL branch_taken: got %b expected 0000010", bt); end
    tests++;
    if (pw !== 7'b0001111) begin fails++; $display("FAIL branch_pending: got %b expected 0001111", pw); end
    tests++;
    if (ps !== 7'b0010000) begin fails++; $display("FAIL branch_pcsrcw: got %b expected 0010000", ps); end
  endtask

  task automatic test_stall();
    logic [3:0] rwSeq;
    InstrD = 20'hE0910;
    tick();
    StallE = 1'b1; ALUFlagsE = 4'b0100; InstrD = 20'hE1510;
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (c == 2) StallE = 1'b0;
      rwSeq[4 - c] = RegWriteM;
      tests++;
      if ({ALUControlE, FlagsE} !== {4'h0, 4'b1010}) begin
        fails++; $display("FAIL stall_hold c%0d: got %h expected %h", c, {ALUControlE, FlagsE}, {4'h0, 4'b1010});
      end
    end
    tick();
    rwSeq[1] = RegWriteM;
    tests++;
    if ({ALUControlE, FlagsE} !== {4'h1, 4'b0100}) begin
      fails++; $display("FAIL stall_release: got %h expected %h", {ALUControlE, FlagsE}, {4'h1, 4'b0100});
    end
    InstrD = 20'hE0810;
    tick();
    rwSeq[0] = RegWriteM;
    tests++;
    if (rwSeq !== 4'b0010) begin fails++; $display("FAIL stall_regwrite_once: got %b expected 0010", rwSeq); end
    InstrD = 20'hE5910;
    tick();
    tests++;
    if ({MemtoRegE, ALUSrcE} !== 2'b11) begin fails++; $display("FAIL ldr_in_e: got %b expected 11", {MemtoRegE, ALUSrcE}); end
    StallE = 1'b1; FlushE = 1'b1;
    tick();
    StallE = 1'b0; FlushE = 1'b0;
    tests++;
    if ({MemtoRegE, ALUSrcE, ALUControlE} !== '0) begin
      fails++; $display("FAIL flush_over_stall: got %b expected 0", {MemtoRegE, ALUSrcE, ALUControlE});
    end
  endtask

  task automatic test_undef();
    logic seen;
    InstrD = 20'hF0810;
    for (int c = 0; c < 4; c++) tick();
    tests++;
    if (RegWriteW !== 1'b0) begin fails++; $display("FAIL cond_never: got %b expected 0", RegWriteW); end
    InstrD = 20'hE0610; #1;
    tests++;
    if (UndefD !== 1'b1) begin fails++; $display("FAIL undef_dp_opcode: got %b expected 1", UndefD); end
    InstrD = 20'hE0810; #1;
    tests++;
    if (UndefD !== 1'b0) begin fails++; $display("FAIL undef_add: got %b expected 0", UndefD); end
    InstrD = 20'hEC000; #1;
    tests++;
    if (UndefD !== 1'b1) begin fails++; $display("FAIL undef_op11: got %b expected 1", UndefD); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen |= MemWriteM | RegWriteW | PCSrcW;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL undef_writes: got %b expected 0", seen); end
  endtask

  task automatic test_random();
    refE_t mE, dec;
    refM_t mM[$];
    refM_t mW, nm;
    logic [3:0] mFlags;
    bit cx, pend;
    reset = 1'b0; #1; reset = 1'b1;
    mE = '0; mW = '0; mFlags = '0;
    mM.delete();
    for (int k = 0; k < MS; k++) mM.push_back('0);
    for (int i = 0; i < 400; i++) begin
      InstrD    = 20'($urandom);
      ALUFlagsE = 4'($urandom);
      StallE    = ($urandom_range(0, 4) == 0);
      FlushE    = ($urandom_range(0, 7) == 0);
      #1;
      dec  = refDecode(InstrD);
      cx   = condHolds(mE.cond, mFlags);
      pend = dec.pcs | mE.pcs;
      foreach (mM[k]) pend |= mM[k].pcs;
      tests++;
      if ({RegSrcD, ImmSrcD, UndefD} !== {dec.rs, dec.is, dec.undef}) begin
        fails++; $display("FAIL rand_decode cyc %0d instr %h: got %b expected %b", i, InstrD,
                          {RegSrcD, ImmSrcD, UndefD}, {dec.rs, dec.is, dec.undef});
      end
      tests++;
      if ({ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, FlagsE} !==
          {mE.src, 4'(mE.alu), mE.br & cx, mE.m2r, mFlags}) begin
        fails++; $display("FAIL rand_execute cyc %0d: got %b expected %b", i,
                          {ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, FlagsE},
                          {mE.src, 4'(mE.alu), mE.br & cx, mE.m2r, mFlags});
      end
      tests++;
      if ({MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF} !==
          {mM[0].mw, mM[0].rw, mW.m2r, mW.rw, mW.pcs, pend}) begin
        fails++; $display("FAIL rand_mem_wb cyc %0d: got %b expected %b", i,
                          {MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF},
                          {mM[0].mw, mM[0].rw, mW.m2r, mW.rw, mW.pcs, pend});
      end
      nm = '0;
      if (!StallE) begin
        nm.rw = mE.rw & cx; nm.mw = mE.mw & cx; nm.m2r = mE.m2r; nm.pcs = mE.pcs & cx;
        if (cx) begin
          if (mE.fw[1]) mFlags[3:2] = ALUFlagsE[3:2];
          if (mE.fw[0]) mFlags[1:0] = ALUFlagsE[1:0];
        end
      end
      mW = mM.pop_back();
      mM.push_front(nm);
      if (FlushE) mE = '0;
      else if (!StallE) mE = dec;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_flag_cond();
    test_compare();
    test_branch();
    test_stall();
    test_undef();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_cond_controller.md
Name: pipe_cond_controller

Overview:
Parametrised successor of the 5-stage pipelined ARM control unit. It decodes InstrD in Decode, carries control through Execute, a configurable number of Memory stages, and Writeback. It evaluates all 15 ARM condition codes against a flags register and supports an extended DP opcode set. It adds an Execute-stage stall and undefined-instruction detection, and sits beside the datapath and hazard unit.

Parameters:
MEM_STAGES, 1, number of Memory pipeline register stages between E and W; legal range 1..4.
ALUCTRL_W, 3, width of ALUControl; must be >= 3.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
InstrD  in  20  instruction bits [31:12] in Decode
ALUFlagsE  in  4  {N,Z,C,V} from the ALU in Execute
StallE  in  1  hold Execute-stage registers
FlushE  in  1  clear Execute-stage registers to a bubble
RegSrcD  out  2  register-source select
ImmSrcD  out  2  immediate-extend select
UndefD  out  1  Decode holds an unimplemented instruction
ALUSrcE  out  1  ALU B-operand select
ALUControlE  out  ALUCTRL_W  ALU operation
BranchTakenE  out  1  branch resolved as taken
MemtoRegE  out  1  load in Execute, for the hazard unit
FlagsE  out  4  current flags register {N,Z,C,V}
MemWriteM  out  1  store enable, first M stage
RegWriteM  out  1  register write, first M stage, for forwarding
MemtoRegW  out  1  writeback select
RegWriteW  out  1  register-file write enable
PCSrcW  out  1  PC written in Writeback
PCWrPendingF  out  1  PC write in flight

Behaviour:
- Decode on op = InstrD[27:26]:
  - 00 is DP; ALUSrc = InstrD[25]; RegWrite = 1; ALUOp = 1.
  - 01 is LDR (InstrD[20] = 1) or STR (InstrD[20] = 0).
  - 10 is B.
  - 11 is undefined.
- DP opcode InstrD[24:21] maps to ALUControl:
  - ADD 0100 -> 000; SUB 0010 -> 001; AND 0000 -> 010; ORR 1100 -> 011; EOR 0001 -> 100; MOV 1101 -> 101.
  - CMP 1010 -> 001 and TST 1000 -> 010; both force RegWrite = 0.
  - Non-DP instructions use 000.
- FlagWrite[1] (N, Z) = S bit (InstrD[20]) of a DP instruction.
- FlagWrite[0] (C, V) = S & (ADD | SUB | CMP).
- Undefined instruction (op = 11, or a DP opcode not listed):
  - UndefD = 1.
  - RegWrite, MemWrite, Branch, PCSrc, MemtoReg and FlagWrite are all forced to 0.
- PCSrcD = (InstrD[15:12] == 1111 & RegWriteD) | BranchD.
- Execute registers hold control, cond and ALUSrc/ALUControl:
  - FlushE = 1: all cleared to 0 on the next edge; flush wins over StallE.
  - StallE = 1 (no flush): all hold their value.
- Condition codes: CondE 0000..1101 follow ARM semantics (EQ..LE); 1110 = AL (always); 1111 = never (CondExE = 0).
- Gated signals: BranchTakenE, and RegWrite/MemWrite/PCSrc gated into M, are each ANDed with CondExE.
- Flags register:
  - Updates only when CondExE & ~StallE.
  - N, Z come from ALUFlagsE[3:2] when FlagWriteE[1].
  - C, V come from ALUFlagsE[1:0] when FlagWriteE[0].
  - FlagsE updates on the edge after the instruction is in E.
- While StallE = 1, the first M stage receives a bubble: all write and PCSrc signals are 0. A stalled instruction therefore enters M exactly once.
- Pipeline depth:
  - The M chain is MEM_STAGES deep; MemWriteM and RegWriteM come from stage 1; W is fed from stage MEM_STAGES.
  - Latency from instruction in E to W outputs is MEM_STAGES + 1 cycles.
- PCWrPendingF = PCSrcD | PCSrcE | OR of PCSrc over all M stages (combinational).
- Reset (reset = 0):
  - All registers, including flags, clear asynchronously, even mid-operation, so every registered output reads 0.
  - Decode outputs remain combinational from InstrD.
  - The first edge after release samples normally.

Test Plan:
- Reset: assert reset = 0 between edges while a branch is in flight -> FlagsE, PCWrPendingF (InstrD = 0xE0810) and all E/M/W outputs go to 0 immediately, before the next edge.
- Flag and condition: ADDS InstrD = 0xE0910 with ALUFlagsE = 0100, then ADDEQ 0x00810 -> FlagsE = 0100 after the first instruction's E edge; the ADDEQ gives RegWriteM = 1; repeating with ALUFlagsE = 0000 gives RegWriteM = 0.
- Compare: CMP InstrD = 0xE1510 -> ALUControlE = 001, RegWriteM = 0; FlagsE takes ALUFlagsE = 1010 (N, C) -> 1010.
- Branch, MEM_STAGES = 2: B InstrD = 0xEA000, one cycle in D ->
  - BranchTakenE = 1 for one cycle.
  - PCWrPendingF high 4 consecutive cycles.
  - PCSrcW high 3 cycles after E.
- Stall: ADDS with ALUFlagsE = 0100, StallE = 1 for 2 cycles -> ALUControlE held; M sees a bubble for 2 cycles and RegWriteM pulses once after release; FlagsE written once; FlushE and StallE together clear E.
- Undefined: InstrD = 0xEC000 -> UndefD = 1; MemWriteM, RegWriteW and PCSrcW stay 0 throughout.
